// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundles the control sequencer's datapath-facing signals.
//   master : the sequencer (drives control strobes, samples instruction
//            fields, ALU Zero flag and memory MemReady)
//   slave  : the datapath/memory side (the opposite directions)
//   Signals:
//     OpCode[5:0], Funct[5:0]  instruction fields from the IR
//     Zero                     ALU zero flag
//     MemReady                 memory completes the current access
//     PCWrite, PCSource[1:0], IorD, MemRead, MemWrite, IRWrite, MDRWrite,
//     RegWrite, RegDst, MemtoReg, ExtOp, ALUSrcA, ALUSrcB[1:0], ALUSel[1:0]
//                              per-cycle datapath controls
//     InstrDone, Illegal       one-cycle status pulses
//     MemFault                 sticky memory-timeout flag
interface multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MDRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ExtOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUSel;
  logic       InstrDone;
  logic       Illegal;
  logic       MemFault;

  modport master (
    input  OpCode, Funct, Zero, MemReady,
    output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, MDRWrite,
           RegWrite, RegDst, MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUSel,
           InstrDone, Illegal, MemFault
  );

  modport slave (
    output OpCode, Funct, Zero, MemReady,
    input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, MDRWrite,
           RegWrite, RegDst, MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUSel,
           InstrDone, Illegal, MemFault
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore sequencer for a multi-cycle MIPS datapath. Steps the shared
//   ALU/memory datapath through fetch, decode, execute, memory and
//   writeback, waiting on a variable-latency MemReady handshake with a
//   bounded timeout (MemFault, then HALT until reset).
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    multicycle_ctrl_if.master (instruction fields, Zero, MemReady
//            in; datapath controls, InstrDone/Illegal pulses, MemFault out)
//   Parameters:
//     WAIT_MAX  wait cycles a memory access may take before faulting
//     CNT_W     wait counter width, 2**CNT_W must exceed WAIT_MAX
module multicycle_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_MAX);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_fault_q, mem_fault_d;

  // Instruction class decode (IR is stable from DECODE onward)
  logic funct_ok, is_r, is_alu_i, is_mem, is_branch, is_jump;

  always_comb begin
    funct_ok = 1'b0;
    case (bus.Funct)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h02, 6'h2A, 6'h24, 6'h25: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
    is_r      = (bus.OpCode == OP_RTYPE) && funct_ok;
    is_alu_i  = (bus.OpCode == OP_ADDIU) || (bus.OpCode == OP_SLTI) ||
                (bus.OpCode == OP_ORI)   || (bus.OpCode == OP_LUI);
    is_mem    = (bus.OpCode == OP_LW) || (bus.OpCode == OP_SW);
    is_branch = (bus.OpCode == OP_BEQ) || (bus.OpCode == OP_BNE);
    is_jump   = (bus.OpCode == OP_J);
  end

  // Next-state, wait counter and fault flag
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_fault_d = mem_fault_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.MemReady) begin
          // Ready on the cycle the count hits the limit is still a success
          cnt_d = '0;
          case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEM_RD: state_d = S_MEM_WB;
            default:  state_d = S_FETCH;
          endcase
        end else if (cnt_q == CNT_LIMIT) begin
          mem_fault_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_r)           state_d = S_EXEC_R;
        else if (is_alu_i)  state_d = S_EXEC_I;
        else if (is_mem)    state_d = S_MEM_ADDR;
        else if (is_branch) state_d = S_BRANCH;
        else if (is_jump)   state_d = S_JUMP;
        else                state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (bus.OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_WB_ALU, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RST;
    endcase
    // Every memory-wait state starts its access with a fresh count
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR)))
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Moore outputs decoded from state, gated by MemReady/Zero where needed
  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.PCSource  = 2'd0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MDRWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.ExtOp     = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'd0;
    bus.ALUSel    = 2'd0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.PCWrite = bus.MemReady;
        bus.IRWrite = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'd3;
        bus.ExtOp   = 1'b1;
        if (!(is_r || is_alu_i || is_mem || is_branch || is_jump)) begin
          bus.Illegal   = 1'b1;
          bus.InstrDone = 1'b1;
        end
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSel  = 2'd2;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ALUSel  = 2'd3;
        bus.ExtOp   = (bus.OpCode != OP_ORI);
      end
      S_WB_ALU: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = (bus.OpCode == OP_RTYPE);
        bus.InstrDone = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        bus.MemRead  = 1'b1;
        bus.IorD     = 1'b1;
        bus.MDRWrite = bus.MemReady;
      end
      S_MEM_WB: begin
        bus.RegWrite  = 1'b1;
        bus.MemtoReg  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = bus.MemReady;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSel    = 2'd1;
        bus.PCSource  = 2'd1;
        bus.InstrDone = 1'b1;
        bus.PCWrite   = (bus.OpCode == OP_BEQ) ? bus.Zero : ~bus.Zero;
      end
      S_JUMP: begin
        bus.PCWrite   = 1'b1;
        bus.PCSource  = 2'd2;
        bus.InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.MemFault = mem_fault_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS core. It replaces single-cycle decode with a Moore FSM that steps a shared ALU/memory datapath through fetch, decode, execute, memory and writeback. It waits on a variable-latency memory ready handshake, with a bounded timeout. It produces per-cycle datapath enables plus an InstrDone strobe for retirement tracking.

Parameters:
WAIT_MAX, 255, maximum cycles any memory access may wait for MemReady before a fault.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
OpCode  in  6  instruction[31:26] from the instruction register
Funct  in  6  instruction[5:0]
Zero  in  1  ALU zero flag, valid in BRANCH state
MemReady  in  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  out  1  load PC
PCSource  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target
IorD  out  1  memory address source: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MDRWrite  out  1  load memory data register
RegWrite  out  1  register file write
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  writeback source: 0=ALUOut, 1=MDR
ExtOp  out  1  0=zero-extend, 1=sign-extend immediate
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  0=rt, 1=constant 4, 2=extended imm, 3=extended imm<<2
ALUSel  out  2  0=ADD, 1=SUB, 2=decode Funct, 3=decode OpCode
InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
Illegal  out  1  one-cycle pulse when an unsupported OpCode/Funct is decoded
MemFault  out  1  sticky; set on memory timeout, cleared only by reset

Behaviour:
- Supported instructions:
  - R-type (OpCode 0x00): Funct 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x00 sll, 0x02 srl, 0x2A slt, 0x24 and, 0x25 or.
  - I-type and jump: 0x09 addiu, 0x0A slti, 0x0D ori, 0x0F lui, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
- Outputs are a pure function of the registered state, plus MemReady/Zero where noted. Every output not listed for a state is 0.
- Reset:
  - rst_n=0 at an edge forces state RST and clears the wait counter and MemFault, including mid-instruction.
  - In RST all outputs are 0.
  - The first cycle with rst_n=1 in RST moves to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUSel=ADD, PCSource=0.
  - IRWrite and PCWrite are asserted only while MemReady=1; the next state is then DECODE.
  - Otherwise the FSM stays in FETCH and the wait counter increments.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUSel=ADD, ExtOp=1 (branch target into ALUOut). Next state by OpCode:
  - R-type with a supported Funct -> EXEC_R.
  - addiu, slti, ori, lui -> EXEC_I.
  - lw, sw -> MEM_ADDR.
  - beq, bne -> BRANCH.
  - j -> JUMP.
  - Anything else -> pulse Illegal and InstrDone, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUSel=FUNCT. Next state WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUSel=IMM, ExtOp=0 for ori and 1 otherwise. Next state WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst=1 if OpCode=0x00 else 0, InstrDone=1. Next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUSel=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1, MDRWrite=MemReady. Moves to MEM_WB on MemReady; waits otherwise.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. Next state FETCH.
- MEM_WR: MemWrite=1, IorD=1, InstrDone=MemReady. Moves to FETCH on MemReady; waits otherwise.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUSel=SUB, PCSource=1, InstrDone=1. Next state FETCH.
  - PCWrite = Zero for beq (0x04), ~Zero for bne (0x05).
- JUMP: PCWrite=1, PCSource=2, InstrDone=1. Next state FETCH.
- Latency with zero-wait memory (cycles, FETCH to InstrDone inclusive):
  - R-type and I-type ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j: 3.
- Wait counter:
  - Cleared on entry to any memory state and whenever MemReady=1.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with MemReady=0.
  - When it reaches WAIT_MAX with MemReady still 0: MemFault is set and the next state is HALT.
  - MemReady arriving on the same cycle the count reaches WAIT_MAX counts as success; no fault.
- HALT: all outputs 0 except MemFault=1. The FSM stays in HALT until reset.
- MemReady outside FETCH, MEM_RD and MEM_WR is ignored.

Test Plan:
- Reset then add (0x00/0x20), MemReady tied 1 -> states RST,FETCH,DECODE,EXEC_R,WB_ALU. RegWrite=1 and RegDst=1 only in cycle 4; InstrDone pulses once.
- lw (0x23), MemReady low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles; MDRWrite only on the ready cycle; MEM_WB then asserts RegWrite=1, MemtoReg=1, RegDst=0.
- beq (0x04) with Zero=1, then bne (0x05) with Zero=1 -> PCWrite=1, PCSource=1 for beq; PCWrite=0 for bne; each takes 3 cycles.
- ori (0x0D) then slti (0x0A) -> ExtOp=0 in EXEC_I for ori, 1 for slti; ALUSel=3 in both.
- OpCode 0x3F, and R-type Funct 0x18 -> single Illegal pulse in DECODE, no RegWrite or MemWrite, return to FETCH.
- WAIT_MAX=4 and MemReady held 0 in FETCH -> MemFault=1 after 4 wait cycles, then HALT with all strobes 0. rst_n=0 for one cycle -> MemFault=0, FSM in RST.
